// File: rtl/jtpang_objdma.sv
// Sprite-table DMA: takes the Z80 bus, copies object RAM into the back half of a
// double-buffered table, and swaps halves only on a vertical-blank falling edge.
module jtpang_objdma #(
  parameter int AW      = 9,
  parameter int ENTRIES = 128,
  parameter int BPE     = 4,
  parameter int WAIT_VB = 1,
  localparam int RW     = $clog2(ENTRIES*BPE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          lvbl,
  input  logic          dma_go,
  output logic          busrq,
  input  logic          busak_n,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  input  logic [RW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          bank,
  output logic          busy,
  output logic          done
);

  localparam int LEN = ENTRIES*BPE;
  localparam logic [AW:0] CNT_LAST = (AW+1)'(LEN);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [RW:0] RD_LIMIT = (RW+1)'(LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, COPY = 2'd2, REL = 2'd3} state_t;

  state_t        state, next_state;
  logic          pending, swap, lvbl_l;
  logic [AW:0]   cnt;
  logic          start, load, step;
  logic          wr_en;
  logic [RW-1:0] wr_off;
  logic          busrq_d, done_d;
  logic [7:0]    mem [0:(2**(RW+1))-1];

  assign start = (state == IDLE) && (next_state == REQ);
  assign load  = (state == REQ)  && (next_state == COPY);
  assign step  = (state == COPY) && cen && !busak_n;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a go pulse seen in IDLE starts the request at once
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = ((pending || dma_go) && ((WAIT_VB == 0) || !lvbl)) ? REQ : IDLE;
      REQ:     next_state = !busak_n ? COPY : REQ;
      COPY:    next_state = (step && (cnt == CNT_LAST)) ? REL : COPY;
      REL:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: table write strobe, write offset and next registered outputs
  always_comb begin
    wr_en   = step && (cnt != {(AW+1){1'b0}}) && rst_n;
    wr_off  = RW'(cnt - CNT_ONE);
    busrq_d = (next_state == REQ) || (next_state == COPY);
    done_d  = (next_state == REL);
  end

  // Control datapath: request flag, address counter, bank swap and readout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      swap     <= 1'b0;
      lvbl_l   <= 1'b1;
      cnt      <= {(AW+1){1'b0}};
      dma_addr <= {AW{1'b0}};
      busrq    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bank     <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      lvbl_l <= lvbl;
      busrq  <= busrq_d;
      busy   <= busrq_d;
      done   <= done_d;
      if (start) begin
        pending <= 1'b0;
      end else if (dma_go) begin
        pending <= 1'b1;
      end
      if (load) begin
        cnt <= {(AW+1){1'b0}};
      end else if (step) begin
        cnt <= cnt + CNT_ONE;
        // the final step only commits the last byte; the address stays put
        if (cnt < CNT_LAST) begin
          dma_addr <= cnt[AW-1:0];
        end
      end
      // a completion landing on the same edge as the blank edge waits a frame
      if (swap && lvbl_l && !lvbl) begin
        bank <= ~bank;
        swap <= done_d;
      end else if (done_d) begin
        swap <= 1'b1;
      end
      rd_data <= ({1'b0, rd_addr} < RD_LIMIT) ? mem[{bank, rd_addr}] : 8'h00;
    end
  end

  // Table RAM write port, always into the back buffer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{~bank, wr_off}] <= dma_din;
    end
  end

endmodule
